// File: rtl/sram64x34_req_adapter.sv
// Valid/ready request front end for one SRAM1RW64x34 macro: registered active-low
// pin drive, post-reset zero-fill, and a credited response FIFO for read data.
module sram64x34_req_adapter #(
    parameter int ADDR_W        = 6,
    parameter int DATA_W        = 34,
    parameter int RESP_DEPTH    = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);
    localparam int CW = $clog2(RESP_DEPTH + 3);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    logic              init_done_nxt;
    logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
    req_t              req;
    logic              req_acc;
    logic [2:1]        rd_pipe;
    logic [CW-1:0]     fifo_count, occupancy;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
    logic              push, pop;

    assign req = '{write: req_write, addr: req_addr, wdata: req_wdata};

    // Every read in flight holds a FIFO slot; writes are gated too so ready
    // never depends on the payload.
    assign occupancy = fifo_count + CW'(rd_pipe[1]) + CW'(rd_pipe[2]);
    assign req_ready = (state == ST_RUN) && init_done && (occupancy < CW'(RESP_DEPTH));
    assign req_acc   = req_valid && req_ready;

    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        init_done_nxt = init_done;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + 1'b1;
                if (init_cnt == LAST_ADDR) begin
                    state_nxt     = ST_RUN;
                    init_done_nxt = 1'b1;
                end
            end
            ST_RUN: init_done_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            init_done <= init_done_nxt;
        end
    end

    // Pins default to idle each cycle; address and write data hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_csb <= 1'b1;
            sram_web <= 1'b1;
            sram_oeb <= 1'b1;
            sram_a   <= '0;
            sram_i   <= '0;
        end else begin
            sram_csb <= 1'b1;
            sram_web <= 1'b1;
            sram_oeb <= 1'b1;
            if (state == ST_INIT) begin
                sram_csb <= 1'b0;
                sram_web <= 1'b0;
                sram_a   <= init_cnt;
                sram_i   <= '0;
            end else if (req_acc) begin
                sram_csb <= 1'b0;
                sram_a   <= req.addr;
                if (req.write) begin
                    sram_web <= 1'b0;
                    sram_i   <= req.wdata;
                end else begin
                    sram_oeb <= 1'b0;
                end
            end
        end
    end

    // Stage 1: pins registered; stage 2: macro output register loaded.
    always_ff @(posedge clock) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= {rd_pipe[1], req_acc && !req.write};
    end

    assign push       = rd_pipe[2];
    assign pop        = resp_valid && resp_ready;
    assign resp_valid = (fifo_count != '0);
    assign resp_rdata = fifo_mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= sram_o;
    end

    // The credit rule makes a push into a full FIFO unreachable.
    always_ff @(posedge clock) begin
        if (!reset) assert (!(push && fifo_count == CW'(RESP_DEPTH)));
    end

endmodule

// File: tb/tb_sram64x34_req_adapter.sv
// Bench for sram64x34_req_adapter: instance 0 (depth 2, zero-fill) and instance 1
// (depth 4, no zero-fill), each with a behavioural macro and a read scoreboard.
module tb_sram64x34_req_adapter;
    localparam int AW = 6;
    localparam int DW = 34;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] rst, req_valid, req_ready, req_write, resp_valid, resp_ready, init_done;
    logic [1:0] csb, web, oeb;
    logic [AW-1:0] req_addr [2];
    logic [AW-1:0] sram_a [2];
    logic [DW-1:0] req_wdata [2];
    logic [DW-1:0] resp_rdata [2];
    logic [DW-1:0] sram_i [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [64];
        logic [DW-1:0] ref_mem [64];
        logic [DW-1:0] sram_o;
        logic [DW-1:0] exp_q [$];

        sram64x34_req_adapter #(
            .ADDR_W(AW), .DATA_W(DW),
            .RESP_DEPTH(g == 0 ? 2 : 4),
            .INIT_ON_RESET(g == 0 ? 1'b1 : 1'b0)
        ) u_dut (
            .clock(clock), .reset(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_rdata(resp_rdata[g]),
            .init_done(init_done[g]),
            .sram_csb(csb[g]), .sram_web(web[g]), .sram_oeb(oeb[g]),
            .sram_a(sram_a[g]), .sram_i(sram_i[g]), .sram_o(sram_o)
        );

        // Macro powers up with random contents and a registered read port.
        initial begin
            for (int i = 0; i < 64; i++) begin
                mem[i]     = DW'({$urandom(), $urandom()});
                ref_mem[i] = '0;
            end
            sram_o = DW'({$urandom(), $urandom()});
        end

        always @(posedge clock) begin
            if (!csb[g] && !web[g]) mem[sram_a[g]] <= sram_i[g];
            if (!csb[g] && !oeb[g]) sram_o <= mem[sram_a[g]];
        end

        // Handshakes are judged on the negedge before the edge that takes them.
        always @(negedge clock) begin
            if (rst[g]) begin
                exp_q.delete();
                if (g == 0) for (int i = 0; i < 64; i++) ref_mem[i] <= '0;
            end else begin
                if (resp_valid[g] && resp_ready[g]) begin
                    if (exp_q.size() == 0) chk("sb_extra_resp", 1, 0);
                    else chk("sb_rdata", resp_rdata[g], exp_q.pop_front());
                end
                if (req_valid[g] && req_ready[g]) begin
                    if (req_write[g]) ref_mem[req_addr[g]] <= req_wdata[g];
                    else exp_q.push_back(ref_mem[req_addr[g]]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int u, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = a;
        req_wdata[u] = d;
        @(negedge clock);
        while (!req_ready[u] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready[u]) chk("req_timeout", 0, 1);
        step();
        req_valid[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst        = 2'b11;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        resp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ctl", {req_ready[i], resp_valid[i], init_done[i], csb[i], web[i], oeb[i]},
                6'b000111);
            chk("rst_ai", {sram_a[i], sram_i[i]}, 0);
        end
        step();
        rst = 2'b00;

        // Zero-fill on instance 0; instance 1 must be ready at once and stay idle.
        for (int k = 0; k < 64; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk("zf_pins", {csb[0], web[0], oeb[0], sram_a[0], sram_i[0]},
                {3'b001, 6'(k), 34'h0});
            chk("zf_done", {init_done[0], req_ready[0]}, (k == 63) ? 2'b11 : 2'b00);
            chk("ni_idle", {init_done[1], req_ready[1], csb[1], web[1], oeb[1]}, 5'b11111);
        end
        step();

        issue(0, 1'b0, 6'd0, '0);
        issue(0, 1'b0, 6'd31, '0);
        issue(0, 1'b0, 6'd63, '0);
        repeat (4) step();

        // Back-to-back write then read of the same address.
        chk("idle_pins", {csb[0], web[0], oeb[0]}, 3'b111);
        issue(0, 1'b1, 6'd5, 34'h2DEADBEEF);
        issue(0, 1'b0, 6'd5, '0);
        @(negedge clock);
        chk("rd_pins", {csb[0], web[0], oeb[0], sram_a[0]}, {3'b010, 6'd5});
        chk("lat_rv0", resp_valid[0], 0);
        @(negedge clock);
        chk("idle_pins2", {csb[0], web[0], oeb[0]}, 3'b111);
        chk("lat_rv1", resp_valid[0], 0);
        @(negedge clock);
        chk("lat_rv2", resp_valid[0], 1);
        chk("lat_rdata", resp_rdata[0], 34'h2DEADBEEF);
        step();

        // Backpressure: two reads use both credits, the third stalls.
        issue(0, 1'b1, 6'd1, 34'h11);
        issue(0, 1'b1, 6'd2, 34'h22);
        issue(0, 1'b1, 6'd3, 34'h33);
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 6'd1, '0);
        issue(0, 1'b0, 6'd2, '0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 6'd3;
        repeat (4) begin
            @(negedge clock);
            chk("bp_stall", req_ready[0], 0);
        end
        step();
        resp_ready[0] = 1'b1;
        issue(0, 1'b0, 6'd3, '0);
        repeat (5) step();
        chk("bp_drained", g_dut[0].exp_q.size(), 0);

        // Continuous read stream on the deeper instance.
        for (int i = 0; i < 16; i++) issue(1, 1'b1, 6'(8 + i), DW'({$urandom(), $urandom()}));
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr[1] = 6'(8 + i);
            @(negedge clock);
            chk("st_ready", req_ready[1], 1);
            chk("st_cnt_le1", 64'(g_dut[1].u_dut.fifo_count <= 1), 1);
            if (i >= 3) chk("st_rv", resp_valid[1], 1);
            step();
        end
        req_valid[1] = 1'b0;
        repeat (4) step();
        chk("st_drained", g_dut[1].exp_q.size(), 0);

        // Reset instance 1 with one FIFO entry and two reads in flight.
        resp_ready[1] = 1'b0;
        issue(1, 1'b0, 6'd8, '0);
        repeat (3) step();
        issue(1, 1'b0, 6'd9, '0);
        issue(1, 1'b0, 6'd10, '0);
        chk("b_load", {g_dut[1].u_dut.fifo_count, g_dut[1].u_dut.rd_pipe}, {3'd1, 2'b11});
        rst[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("b_rst", {resp_valid[1], req_ready[1], init_done[1], csb[1], web[1], oeb[1]},
            6'b000111);
        step();
        rst[1] = 1'b0;
        resp_ready[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("b_ready", {init_done[1], req_ready[1]}, 2'b11);
        repeat (4) begin
            chk("b_flushed", {resp_valid[1], csb[1]}, 2'b01);
            @(negedge clock);
        end
        step();

        // Reset instance 0 mid-operation; zero-fill must rerun.
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 6'd31, '0);
        repeat (3) step();
        issue(0, 1'b0, 6'd63, '0);
        rst[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("a_rst", {resp_valid[0], req_ready[0], init_done[0], csb[0], web[0], oeb[0]},
            6'b000111);
        step();
        rst[0] = 1'b0;
        resp_ready[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end while (!init_done[0] && n < 100);
        chk("a_reinit_edges", n, 64);
        step();
        issue(0, 1'b0, 6'd5, '0);
        repeat (4) step();
        chk("a_drained", g_dut[0].exp_q.size(), 0);
        chk("b_drained", g_dut[1].exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram64x34_req_adapter.md
Name: sram64x34_req_adapter

Overview:
- Request/response front end for one SRAM1RW64x34 macro.
- Accepts valid/ready read and write requests and drives the macro's active-low control pins from registers.
- Captures read data into a small response FIFO, with credit-based backpressure so read data is never dropped.
- After reset, zero-fills the whole array, because the macro powers up with random contents.

Parameters:
- ADDR_W, 6: address width; the array depth is 2**ADDR_W = 64.
- DATA_W, 34: data word width.
- RESP_DEPTH, 2: response FIFO entries; legal range is 2..4.
- INIT_ON_RESET, 1: 1 = zero-fill the array after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  Block clock. The parent ties the macro's CE to this same clock.
- reset  in  1  Synchronous, active-high reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Request accepted when req_valid & req_ready at a clock edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  Word address.
- req_wdata  in  DATA_W  Write data.
- resp_valid  out  1  Read data available.
- resp_ready  in  1  Consumer takes the response when resp_valid & resp_ready at a clock edge.
- resp_rdata  out  DATA_W  Read data at the FIFO head.
- init_done  out  1  Zero-fill complete.
- sram_csb  out  1  Macro chip select, active low.
- sram_web  out  1  Macro write enable, active low.
- sram_oeb  out  1  Macro read enable, active low.
- sram_a  out  ADDR_W  Macro address.
- sram_i  out  DATA_W  Macro write data.
- sram_o  in  DATA_W  Macro read data. It is registered inside the macro and updates on the clock edge after the read pins are sampled.

Behaviour:
- Reset is synchronous, active-high, with one clock. In the cycle after any reset edge:
  - req_ready=0, resp_valid=0, init_done=0.
  - sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0.
  - FIFO empty; pipeline flags cleared; state=INIT, or RUN if INIT_ON_RESET=0.
- Reset mid-operation discards in-flight reads and FIFO contents. Array contents written before the reset are not guaranteed to survive, because the zero-fill reruns.
- All sram_* outputs are registered. Pin encoding per registered cycle:
  - idle: csb=1, web=1, oeb=1.
  - read: csb=0, oeb=0, web=1.
  - write: csb=0, web=0, oeb=1.
  - sram_i only matters on writes; otherwise it holds its last value.
- FSM has two states, INIT and RUN:
  - INIT: a counter runs 0..63. Clock edges 1..64 after reset release each register a write of 0 to address k. On edge 64 the state goes to RUN and init_done=1.
  - INIT: req_ready=0 throughout.
  - RUN: terminal until reset; init_done stays 1.
  - If INIT_ON_RESET=0, the state is RUN and init_done=1 from the first edge after reset release.
- Request acceptance, RUN only:
  - req_ready = (state==RUN) & (credits>0).
  - credits = RESP_DEPTH - (fifo_count + rd_s1 + rd_s2). Credits are checked for writes as well, so ready does not depend on the payload.
  - At most one request per cycle.
- Pipeline for a request accepted at edge N:
  - Edge N: pins registered; rd_s1 = is_read.
  - Edge N+1: macro acts; rd_s2 = rd_s1.
  - Edge N+2: if rd_s2, push sram_o into the FIFO. resp_valid is high in the cycle after edge N+2.
  - Read latency is 2 cycles from acceptance to resp_valid when the FIFO is empty.
- Write then read to the same address on consecutive accepts returns the new data, since the macro writes at N+1 and the read samples at N+2.
- Response FIFO:
  - resp_valid = (fifo_count>0); resp_rdata = head entry; responses leave in request order.
  - Push and pop in the same cycle leave the count unchanged. When empty, a push is not bypassed, so data is visible the next cycle.
  - Overflow is impossible by the credit rule. A push while full is a design error and is flagged by an assertion.
- Writes produce no response.
- No combinational path from resp_ready or req_valid to any sram_* output or to resp_valid.

Test Plan:
- Zero-fill: INIT_ON_RESET=1; release reset.
  - Required: init_done and req_ready rise exactly 64 edges later.
  - Required: pins show 64 writes at addresses 0..63 with data 0 and csb=0, web=0.
  - Then read addresses 0, 31 and 63. Required: each returns 0x0.
- Write/read back-to-back: write 0x2_DEAD_BEEF to address 5, then read 5 on the next cycle.
  - Required: resp_valid 2 cycles after the read is accepted, resp_rdata=0x2DEADBEEF.
  - Required: idle pins are csb=1, web=1, oeb=1 between operations.
- Backpressure: RESP_DEPTH=2, resp_ready=0, stream reads of addresses 1, 2, 3 holding values 0x11, 0x22, 0x33.
  - Required: the third read stalls with req_ready=0 while 2 credits are used.
  - Raise resp_ready. Required: responses 0x11, 0x22, 0x33 in order, no loss, no duplicates.
- Simultaneous push/pop: resp_ready=1 with a continuous read stream.
  - Required: one response per cycle.
  - Required: fifo_count stays at or below 1.
  - Required: req_ready stays 1.
- Reset mid-operation: assert reset with 2 reads in flight and 1 FIFO entry held.
  - Required: the next cycle shows resp_valid=0, req_ready=0, init_done=0, all sram control pins high.
  - Required: the zero-fill reruns; a read of the previously written address 5 returns 0.
- No init: INIT_ON_RESET=0.
  - Required: init_done=1 and req_ready=1 one cycle after reset release.
  - Required: no writes appear on the pins until a request is accepted.
